// File: rtl/serial_fb_loader_pkg.sv
// Shared types and constants for the serial framebuffer loader.
package serial_fb_loader_pkg;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        ESC     = 2'd1,
        ADDR_HI = 2'd2,
        ADDR_LO = 2'd3
    } state_t;

    localparam logic [7:0] CMD_HOME    = 8'h00;
    localparam logic [7:0] CMD_SETADDR = 8'h01;
    localparam int         FB_DEPTH    = 9600;

endpackage

// File: rtl/serial_fb_loader.sv
// UART-to-video-RAM loader: auto-incrementing pixel writes plus FF-escaped address commands.
// Optional echo of every accepted byte when SERIAL_FB_LOADER_ECHO_EN is defined.
module serial_fb_loader
    import serial_fb_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 14,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FB_DEPTH   = serial_fb_loader_pkg::FB_DEPTH,
    parameter logic [DATA_WIDTH-1:0] ESC_BYTE   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_reset_n,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic                  tx_ready,
    output logic                  tx_load,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  echo_overrun
);

    localparam int                    HI_W      = ADDR_WIDTH - DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(FB_DEPTH);

    state_t                state, state_nxt;
    logic [1:0]            ack_pipe;
    logic                  accept;
    logic                  do_wr;
    logic                  hi_ld;
    logic [HI_W-1:0]       addr_hi;
    logic [ADDR_WIDTH-1:0] set_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    // ack_pipe[0] drives the acknowledge low; ack_pipe[1] is the holdoff cycle after it
    assign accept     = rx_ready & ~(|ack_pipe);
    assign rx_reset_n = ~ack_pipe[0];
    assign set_addr   = {addr_hi, rx_data};
    assign addr_inc   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state <= DATA;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_wr     = 1'b0;
        hi_ld     = 1'b0;
        addr_nxt  = cur_addr;
        if (accept) begin
            case (state)
                DATA: begin
                    if (rx_data == ESC_BYTE) state_nxt = ESC;
                    else                     do_wr     = 1'b1;
                end
                ESC: begin
                    state_nxt = DATA;
                    if (rx_data == DATA_WIDTH'(CMD_HOME))         addr_nxt  = '0;
                    else if (rx_data == DATA_WIDTH'(CMD_SETADDR)) state_nxt = ADDR_HI;
                    else if (rx_data == ESC_BYTE)                 do_wr     = 1'b1;
                end
                ADDR_HI: begin
                    hi_ld     = 1'b1;
                    state_nxt = ADDR_LO;
                end
                ADDR_LO: begin
                    state_nxt = DATA;
                    addr_nxt  = ({1'b0, set_addr} >= DEPTH_X) ? '0 : set_addr;
                end
                default: state_nxt = DATA;
            endcase
            if (do_wr) addr_nxt = addr_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_pipe   <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            frame_done <= 1'b0;
            cur_addr   <= '0;
            addr_hi    <= '0;
        end else begin
            ack_pipe   <= {ack_pipe[0], accept};
            ram_we     <= do_wr;
            frame_done <= do_wr && (cur_addr == LAST_ADDR);
            cur_addr   <= addr_nxt;
            if (do_wr) begin
                ram_addr <= cur_addr;
                ram_data <= rx_data;
            end
            if (hi_ld) addr_hi <= rx_data[HI_W-1:0];
        end
    end

`ifdef SERIAL_FB_LOADER_ECHO_EN
    // tx_ready is sampled in the accept cycle so the load lands alongside the acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_load      <= 1'b0;
            tx_data      <= '0;
            echo_overrun <= 1'b0;
        end else begin
            tx_load <= accept & tx_ready;
            if (accept & tx_ready) tx_data <= rx_data;
            if (accept & ~tx_ready) echo_overrun <= 1'b1;
        end
    end
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready;
    assign tx_load         = 1'b0;
    assign tx_data         = '0;
    assign echo_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_fb_loader.sv
// Directed bench for serial_fb_loader; echo checks follow SERIAL_FB_LOADER_ECHO_EN.
module tb_serial_fb_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_reset_n;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_data;
    logic        frame_done;
    logic [13:0] cur_addr;
    logic        tx_ready;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        echo_overrun;

    int total = 0;
    int bad   = 0;

    // observations from cycle N+1 (o1_*) and N+2 (o2_*) of the last sent byte
    logic        o1_ack_n, o1_we, o1_fd, o1_txl, o1_ovr;
    logic [13:0] o1_addr, o1_cur;
    logic [7:0]  o1_data, o1_txd;
    logic        o2_ack_n, o2_we;
    logic [13:0] o2_addr;

    serial_fb_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_reset_n   (rx_reset_n),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .frame_done   (frame_done),
        .cur_addr     (cur_addr),
        .tx_ready     (tx_ready),
        .tx_load      (tx_load),
        .tx_data      (tx_data),
        .echo_overrun (echo_overrun)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        n = 1;
        while (rx_reset_n !== 1'b0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (rx_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL ack_timeout byte=%h rx_reset_n=%b want 0", b, rx_reset_n);
        end
        o1_ack_n = rx_reset_n; o1_we = ram_we; o1_fd = frame_done;
        o1_addr  = ram_addr;   o1_data = ram_data; o1_cur = cur_addr;
        o1_txl   = tx_load;    o1_txd = tx_data;   o1_ovr = echo_overrun;
        rx_ready = 1'b0;
        @(posedge clk); #1;
        o2_ack_n = rx_reset_n; o2_we = ram_we; o2_addr = ram_addr;
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rx_reset_n, ram_we, ram_addr, ram_data, frame_done, cur_addr, tx_load, tx_data, echo_overrun}
            !== {1'b1, 1'b0, 14'd0, 8'd0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values ack_n=%b we=%b addr=%0d data=%h fd=%b cur=%0d txl=%b txd=%h ovr=%b",
                     rx_reset_n, ram_we, ram_addr, ram_data, frame_done, cur_addr, tx_load, tx_data, echo_overrun);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_basic;
        send(8'h12);
        total++;
        if ({o1_ack_n, o1_we, o1_addr, o1_data, o1_cur, o1_fd} !== {1'b0, 1'b1, 14'd0, 8'h12, 14'd1, 1'b0}) begin
            bad++;
            $display("FAIL basic_w0 ack_n=%b we=%b addr=%0d data=%h cur=%0d fd=%b want 0 1 0 12 1 0",
                     o1_ack_n, o1_we, o1_addr, o1_data, o1_cur, o1_fd);
        end
        total++;
        if ({o2_ack_n, o2_we} !== 2'b10) begin
            bad++;
            $display("FAIL basic_ack_pulse0 ack_n=%b we=%b want 1 0", o2_ack_n, o2_we);
        end
        send(8'h34);
        total++;
        if ({o1_ack_n, o1_we, o1_addr, o1_data, o1_cur} !== {1'b0, 1'b1, 14'd1, 8'h34, 14'd2}) begin
            bad++;
            $display("FAIL basic_w1 ack_n=%b we=%b addr=%0d data=%h cur=%0d want 0 1 1 34 2",
                     o1_ack_n, o1_we, o1_addr, o1_data, o1_cur);
        end
        total++;
        if ({o2_ack_n, o2_we, o2_addr} !== {1'b1, 1'b0, 14'd1}) begin
            bad++;
            $display("FAIL basic_ack_pulse1 ack_n=%b we=%b addr_hold=%0d want 1 0 1", o2_ack_n, o2_we, o2_addr);
        end
    endtask

    task automatic test_setaddr_wrap;
        logic [7:0] seq [4];
        int nwe = 0;
        seq = '{8'hFF, 8'h01, 8'h25, 8'h7F};
        foreach (seq[i]) begin
            send(seq[i]);
            if (o1_we === 1'b1) nwe++;
        end
        total++;
        if (nwe != 0 || o1_cur !== 14'd9599) begin
            bad++;
            $display("FAIL setaddr_9599 writes=%0d cur=%0d want 0 9599", nwe, o1_cur);
        end
        send(8'hAA);
        total++;
        if ({o1_we, o1_addr, o1_data, o1_fd, o1_cur} !== {1'b1, 14'd9599, 8'hAA, 1'b1, 14'd0}) begin
            bad++;
            $display("FAIL wrap we=%b addr=%0d data=%h fd=%b cur=%0d want 1 9599 aa 1 0",
                     o1_we, o1_addr, o1_data, o1_fd, o1_cur);
        end
    endtask

    task automatic test_setaddr_oob;
        logic [7:0] seq [4];
        int nwe = 0;
        seq = '{8'hFF, 8'h01, 8'h25, 8'h80};
        send(8'h11);
        total++;
        if ({o1_we, o1_addr, o1_fd, o1_cur} !== {1'b1, 14'd0, 1'b0, 14'd1}) begin
            bad++;
            $display("FAIL oob_pre we=%b addr=%0d fd=%b cur=%0d want 1 0 0 1", o1_we, o1_addr, o1_fd, o1_cur);
        end
        foreach (seq[i]) begin
            send(seq[i]);
            if (o1_we === 1'b1) nwe++;
        end
        total++;
        if (nwe != 0 || o1_cur !== 14'd0) begin
            bad++;
            $display("FAIL oob_9600 writes=%0d cur=%0d want 0 0", nwe, o1_cur);
        end
    endtask

    task automatic test_escape;
        send(8'hFF);
        send(8'hFF);
        total++;
        if ({o1_we, o1_addr, o1_data, o1_cur} !== {1'b1, 14'd0, 8'hFF, 14'd1}) begin
            bad++;
            $display("FAIL esc_literal we=%b addr=%0d data=%h cur=%0d want 1 0 ff 1", o1_we, o1_addr, o1_data, o1_cur);
        end
        send(8'hFF);
        send(8'h00);
        total++;
        if ({o1_ack_n, o1_we, o1_cur} !== {1'b0, 1'b0, 14'd0}) begin
            bad++;
            $display("FAIL esc_home ack_n=%b we=%b cur=%0d want 0 0 0", o1_ack_n, o1_we, o1_cur);
        end
        send(8'h55);
        total++;
        if ({o1_we, o1_addr, o1_data, o1_cur} !== {1'b1, 14'd0, 8'h55, 14'd1}) begin
            bad++;
            $display("FAIL esc_after_home we=%b addr=%0d data=%h cur=%0d want 1 0 55 1", o1_we, o1_addr, o1_data, o1_cur);
        end
        send(8'hFF);
        send(8'h07);
        total++;
        if ({o1_we, o1_cur} !== {1'b0, 14'd1}) begin
            bad++;
            $display("FAIL esc_unknown we=%b cur=%0d want 0 1", o1_we, o1_cur);
        end
        send(8'h08);
        total++;
        if ({o1_we, o1_addr, o1_data, o1_cur} !== {1'b1, 14'd1, 8'h08, 14'd2}) begin
            bad++;
            $display("FAIL esc_unknown_next we=%b addr=%0d data=%h cur=%0d want 1 1 08 2", o1_we, o1_addr, o1_data, o1_cur);
        end
    endtask

    task automatic test_reset_mid;
        send(8'hFF);
        send(8'h01);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rx_reset_n, ram_we, cur_addr, ram_addr, ram_data} !== {1'b1, 1'b0, 14'd0, 14'd0, 8'd0}) begin
            bad++;
            $display("FAIL midreset_state ack_n=%b we=%b cur=%0d addr=%0d data=%h want 1 0 0 0 00",
                     rx_reset_n, ram_we, cur_addr, ram_addr, ram_data);
        end
        @(negedge clk); reset = 1'b0;
        send(8'h07);
        total++;
        if ({o1_we, o1_addr, o1_data, o1_cur} !== {1'b1, 14'd0, 8'h07, 14'd1}) begin
            bad++;
            $display("FAIL midreset_data we=%b addr=%0d data=%h cur=%0d want 1 0 07 1", o1_we, o1_addr, o1_data, o1_cur);
        end
    endtask

    task automatic test_reset_wins;
        repeat (2) @(negedge clk);
        rx_ready = 1'b1; rx_data = 8'h99; reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rx_reset_n, ram_we, cur_addr, ram_data} !== {1'b1, 1'b0, 14'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_wins ack_n=%b we=%b cur=%0d data=%h want 1 0 0 00", rx_reset_n, ram_we, cur_addr, ram_data);
        end
        rx_ready = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({rx_reset_n, ram_we} !== 2'b10) begin
            bad++;
            $display("FAIL reset_wins_after ack_n=%b we=%b want 1 0", rx_reset_n, ram_we);
        end
    endtask

    task automatic test_echo;
        tx_ready = 1'b0;
        send(8'h42);
`ifdef SERIAL_FB_LOADER_ECHO_EN
        total++;
        if ({o1_txl, o1_ovr} !== 2'b01) begin
            bad++;
            $display("FAIL echo_drop txl=%b ovr=%b want 0 1", o1_txl, o1_ovr);
        end
        tx_ready = 1'b1;
        send(8'h42);
        total++;
        if ({o1_txl, o1_txd, o1_ovr} !== {1'b1, 8'h42, 1'b1}) begin
            bad++;
            $display("FAIL echo_load txl=%b txd=%h ovr=%b want 1 42 1", o1_txl, o1_txd, o1_ovr);
        end
        send(8'hFF);
        total++;
        if ({o1_txl, o1_txd} !== {1'b1, 8'hFF}) begin
            bad++;
            $display("FAIL echo_cmd txl=%b txd=%h want 1 ff", o1_txl, o1_txd);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (echo_overrun !== 1'b0) begin
            bad++;
            $display("FAIL echo_ovr_clear ovr=%b want 0", echo_overrun);
        end
        @(negedge clk); reset = 1'b0;
`else
        total++;
        if ({o1_txl, o1_txd, o1_ovr} !== {1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL echo_off txl=%b txd=%h ovr=%b want 0 00 0", o1_txl, o1_txd, o1_ovr);
        end
        tx_ready = 1'b1;
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_setaddr_wrap;
        test_setaddr_oob;
        test_escape;
        test_reset_mid;
        test_reset_wins;
        test_echo;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
